medidor_distancia_3s: RTL and testbench
=======================================

# medidor_distancia_3s

Three-sensor ultrasonic front end for the tank-level controller. On each `medir` request it fires the three HC-SR04 sensors one after another, times each echo pulse, converts each width to whole centimetres and delivers a single fused distance plus per-sensor validity. It sits directly upstream of the level/valve/buzzer control logic, which consumes `distancia` on the `pronto` pulse.

## Interface
- `CLK_FREQ_MHZ`, 50: clock frequency in MHz; sets all µs-to-cycle conversions.
- `TRIG_US`, 10: trigger pulse width, in µs.
- `TIMEOUT_US`, 30000: maximum time for the echo to rise, and maximum echo high time, in µs.
- `GAP_US`, 100: idle time between the end of one sensor's measurement and the next trigger, in µs.
- `CICLOS_POR_CM`, 2941: clock cycles of echo per centimetre (58.82 µs/cm at 50 MHz).
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `medir` in 1: start request, level-sampled; accepted only in INICIAL.
- `echo1`, `echo2`, `echo3` in 1 each: sensor echo inputs, asynchronous.
- `trigger1`, `trigger2`, `trigger3` out 1 each: sensor trigger outputs.
- `distancia` out 9: fused distance in cm.
- `validos` out 3: bit i-1 is set when sensor i returned a valid echo in the last cycle.
- `erro` out 1: no sensor was valid in the last cycle.
- `pronto` out 1: one-clock pulse when `distancia`, `validos` and `erro` update.
- `db_estado` out 4: current FSM state code.

## Operation
- Echo inputs pass through a 2-flop synchronizer before use. The echo edge is detected on the synchronized signal.
- FSM states, with codes in parentheses:
  - INICIAL(0): waits for `medir`=1, clears the sensor index `i` to 1, then moves to TRIGGER.
  - TRIGGER(1): holds `trigger[i]`=1 for TRIG_US·CLK_FREQ_MHZ cycles, then moves to ESPERA_ECHO.
  - ESPERA_ECHO(2): on a synchronized echo rise, goes to MEDE. If the timeout count elapses first, marks sensor i invalid and goes to GAP.
  - MEDE(3): counts cycles in a sub-counter that wraps at CICLOS_POR_CM-1, incrementing the cm counter on each wrap, so the result truncates. On echo fall, stores the cm value for sensor i, marks it valid and goes to GAP. If the echo is still high when the timeout elapses, marks sensor i invalid and goes to GAP.
  - GAP(4): waits GAP_US. Then goes to TRIGGER with i+1 if i<3, otherwise to CALCULA.
  - CALCULA(5): fuses the three results (see Configuration), registers the outputs, then goes to FINAL.
  - FINAL(6): asserts `pronto` for 1 cycle, then returns to INICIAL.
- The cm counter saturates at 511 and never wraps.
- Only one trigger is ever high at a time. Triggers are 0 in all other states.
- `medir` is ignored while busy; there is no queuing. If `medir` is held high, a new cycle starts on the clock after FINAL.
- Fusion rules, with valid readings only:
  - 3 valid: the median.
  - 2 valid: the smaller value (the conservative choice, meaning a higher water level).
  - 1 valid: that value.
  - 0 valid: `erro`=1 and `distancia` holds its previous value.
- An echo already high when ESPERA_ECHO is entered is not a rise. The FSM waits for a 0→1 transition.

## Timing
- Reset (asserted low) immediately sets the state to INICIAL and forces all outputs and counters to 0, including `distancia`, `validos`, `erro`, `pronto` and the triggers. A reset mid-measurement aborts the cycle and drops any active trigger at once.
- From `medir` sampled high to `trigger1` rising: 1 cycle.
- Echo measurement latency: 2 cycles of synchronizer delay on both edges, which cancel in the width.
- From the echo3 fall (or sensor 3 timeout) to `pronto`: 2 synchronizer cycles + GAP_US·CLK_FREQ_MHZ + 2 cycles.
- Outputs change only in the cycle where `pronto`=1 and are stable until the next `pronto`.

## Configuration
- `MEDIANA_EN`:
  - Defined: uses the fusion rules above.
  - Undefined: `distancia` reports sensor 1 only, and `erro` is set when sensor 1 is invalid. Sensors 2 and 3 are still triggered and measured so that `validos` stays complete; the comparator logic is removed.

## Test plan
- All echoes 4353 µs, 400 µs after each trigger -> `distancia`=74, `validos`=111, `erro`=0, one `pronto` pulse.
- All echoes 5899 µs -> `distancia`=100, from 294950 cycles / 2941 with truncation.
- Echoes 117 µs, 1167 µs and 4353 µs on sensors 1–3 -> `distancia`=19, the median (MEDIANA_EN defined). With the macro undefined, the same stimulus gives `distancia`=1.
- Sensor 2 never answers and the others give 1167 µs -> after the 30 ms timeout, `validos`=101 and `distancia`=19. No echoes at all -> `erro`=1, `distancia` unchanged, `validos`=000.
- Echo held high for more than 30 ms -> sensor marked invalid; no 511 value is stored.
- `reset` pulled low during MEDE of sensor 2 -> `trigger2` is 0 at once, all outputs are 0, no `pronto`. After release and `medir`, a clean full cycle completes.

Source files
------------

// File: rtl/medidor_distancia_3s.sv
// -----------------------------------------------------------------------------
// medidor_distancia_3s
//
// Three-sensor ultrasonic (HC-SR04) front end. Each `medir` request fires the
// sensors one after another, times each echo pulse in whole centimetres and
// delivers one fused distance plus per-sensor validity on a `pronto` pulse.
//
// Build option (macro MEDIANA_EN):
//   defined   : fused distance = median (3 valid), minimum (2 valid),
//               the single value (1 valid), held with erro=1 (0 valid).
//   undefined : distance taken from sensor 1 only, erro = sensor 1 invalid;
//               sensors 2 and 3 are still measured so `validos` is complete.
//
// Ports:
//   clock                  system clock, rising edge
//   reset                  asynchronous active-low reset
//   medir                  start request, accepted only in INICIAL
//   echo1..echo3           asynchronous echo inputs
//   trigger1..trigger3     sensor trigger outputs (at most one high)
//   distancia[8:0]         fused distance in cm
//   validos[2:0]           bit i-1 = sensor i valid in the last cycle
//   erro                   no usable reading in the last cycle
//   pronto                 one-clock pulse when the results update
//   db_estado[3:0]         current FSM state code
// -----------------------------------------------------------------------------
module medidor_distancia_3s #(
  parameter int CLK_FREQ_MHZ  = 50,
  parameter int TRIG_US       = 10,
  parameter int TIMEOUT_US    = 30000,
  parameter int GAP_US        = 100,
  parameter int CICLOS_POR_CM = 2941
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo1,
  input  logic       echo2,
  input  logic       echo3,
  output logic       trigger1,
  output logic       trigger2,
  output logic       trigger3,
  output logic [8:0] distancia,
  output logic [2:0] validos,
  output logic       erro,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TRIG_CYC = TRIG_US * CLK_FREQ_MHZ;
  localparam int TOUT_CYC = TIMEOUT_US * CLK_FREQ_MHZ;
  localparam int GAP_CYC  = GAP_US * CLK_FREQ_MHZ;
  localparam int TMR_W    = $clog2(TRIG_CYC + TOUT_CYC + GAP_CYC + 1);
  localparam int SUB_W    = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    TRIGGER     = 4'd1,
    ESPERA_ECHO = 4'd2,
    MEDE        = 4'd3,
    GAP         = 4'd4,
    CALCULA     = 4'd5,
    FINAL       = 4'd6
  } estado_t;

  estado_t state_q, state_d;

  logic [1:0]       idx_q, idx_d;        // 0..2 selects sensor 1..3
  logic [TMR_W-1:0] timer_q, timer_d;    // shared trigger/timeout/gap timer
  logic [SUB_W-1:0] sub_q, sub_d;        // cycles within the current cm
  logic [8:0]       cm_q, cm_d;          // saturating cm counter
  logic [2:0][8:0]  res_q, res_d;        // per-sensor results in cm
  logic [2:0]       val_q, val_d;        // per-sensor validity
  logic [8:0]       dist_q, dist_d;
  logic [2:0]       validos_q, validos_d;
  logic             erro_q, erro_d;

  // Echo synchronizer (two flops) plus one delayed copy for edge detection.
  logic [2:0] echo_raw, meta_q, sync_q, prev_q;
  assign echo_raw = {echo3, echo2, echo1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= echo_raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  logic cur_echo, cur_rise;
  // A line that is already high has prev=1, so only a true 0->1 counts.
  assign cur_echo = sync_q[idx_q];
  assign cur_rise = sync_q[idx_q] & ~prev_q[idx_q];

  logic trig_done, tout_done, gap_done;
  assign trig_done = (timer_q == TMR_W'(TRIG_CYC - 1));
  assign tout_done = (timer_q == TMR_W'(TOUT_CYC - 1));
  assign gap_done  = (timer_q == TMR_W'(GAP_CYC - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INICIAL:     if (medir) state_d = TRIGGER;
      TRIGGER:     if (trig_done) state_d = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (cur_rise)       state_d = MEDE;
        else if (tout_done) state_d = GAP;
      end
      MEDE:        if (!cur_echo || tout_done) state_d = GAP;
      GAP:         if (gap_done) state_d = (idx_q == 2'd2) ? CALCULA : TRIGGER;
      CALCULA:     state_d = FINAL;
      FINAL:       state_d = INICIAL;
      default:     state_d = INICIAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    trigger1  = 1'b0;
    trigger2  = 1'b0;
    trigger3  = 1'b0;
    if (state_q == TRIGGER) begin
      trigger1 = (idx_q == 2'd0);
      trigger2 = (idx_q == 2'd1);
      trigger3 = (idx_q == 2'd2);
    end
    pronto    = (state_q == FINAL);
    db_estado = state_q;
  end

  assign distancia = dist_q;
  assign validos   = validos_q;
  assign erro      = erro_q;

`ifdef MEDIANA_EN
  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [8:0] med3(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c);
    return max9(min9(a, b), min9(max9(a, b), c));
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d     = idx_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    res_d     = res_q;
    val_d     = val_q;
    dist_d    = dist_q;
    validos_d = validos_q;
    erro_d    = erro_q;

    // The timer restarts on every state change so each phase times from 0.
    if (state_d != state_q || state_q == INICIAL) timer_d = '0;
    else                                          timer_d = timer_q + TMR_W'(1);

    unique case (state_q)
      INICIAL: if (medir) idx_d = 2'd0;
      ESPERA_ECHO: begin
        if (cur_rise) begin
          // The rise cycle is already one cycle of echo width.
          sub_d = SUB_W'(1);
          cm_d  = '0;
        end else if (tout_done) begin
          val_d[idx_q] = 1'b0;
        end
      end
      MEDE: begin
        if (!cur_echo) begin
          res_d[idx_q] = cm_q;
          val_d[idx_q] = 1'b1;
        end else if (tout_done) begin
          val_d[idx_q] = 1'b0;
        end else if (sub_q == SUB_W'(CICLOS_POR_CM - 1)) begin
          sub_d = '0;
          cm_d  = (cm_q == 9'd511) ? 9'd511 : cm_q + 9'd1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      GAP: if (gap_done && idx_q != 2'd2) idx_d = idx_q + 2'd1;
      CALCULA: begin
        validos_d = val_q;
`ifdef MEDIANA_EN
        erro_d = (val_q == 3'b000);
        unique case (val_q)
          3'b111:  dist_d = med3(res_q[0], res_q[1], res_q[2]);
          3'b011:  dist_d = min9(res_q[0], res_q[1]);
          3'b101:  dist_d = min9(res_q[0], res_q[2]);
          3'b110:  dist_d = min9(res_q[1], res_q[2]);
          3'b001:  dist_d = res_q[0];
          3'b010:  dist_d = res_q[1];
          3'b100:  dist_d = res_q[2];
          default: dist_d = dist_q;
        endcase
`else
        erro_d = ~val_q[0];
        if (val_q[0]) dist_d = res_q[0];
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q     <= '0;
      timer_q   <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      res_q     <= '0;
      val_q     <= '0;
      dist_q    <= '0;
      validos_q <= '0;
      erro_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      res_q     <= res_d;
      val_q     <= val_d;
      dist_q    <= dist_d;
      validos_q <= validos_d;
      erro_q    <= erro_d;
    end
  end

endmodule

// File: tb/tb_medidor_distancia_3s.sv
module tb_medidor_distancia_3s;

  // Scaled-down timing: 1 cycle per us, 10 cycles per cm, 1000-cycle timeout.
  localparam int CLK_FREQ_MHZ  = 1;
  localparam int TRIG_US       = 10;
  localparam int TIMEOUT_US    = 1000;
  localparam int GAP_US        = 100;
  localparam int CICLOS_POR_CM = 10;
  localparam int ECHO_DLY      = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       medir = 1'b0;
  logic [2:0] echo_drv = 3'b000;
  logic       trigger1, trigger2, trigger3;
  logic [8:0] distancia;
  logic [2:0] validos;
  logic       erro, pronto;
  logic [3:0] db_estado;
  logic [2:0] trig;

  assign trig = {trigger3, trigger2, trigger1};

  medidor_distancia_3s #(
    .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
    .TRIG_US      (TRIG_US),
    .TIMEOUT_US   (TIMEOUT_US),
    .GAP_US       (GAP_US),
    .CICLOS_POR_CM(CICLOS_POR_CM)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo1    (echo_drv[0]),
    .echo2    (echo_drv[1]),
    .echo3    (echo_drv[2]),
    .trigger1 (trigger1),
    .trigger2 (trigger2),
    .trigger3 (trigger3),
    .distancia(distancia),
    .validos  (validos),
    .erro     (erro),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0] d;
    logic [2:0] v;
    logic       e;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pronto_cnt = 0;
  int   width [3] = '{0, 0, 0};
  logic overlap_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sensor model: after its trigger falls, waits ECHO_DLY cycles and returns
  // an echo of width[k] cycles (0 = no answer).
  task automatic sensor(input int k);
    forever begin
      wait (trig[k] === 1'b1);
      wait (trig[k] === 1'b0);
      if (width[k] > 0) begin
        repeat (ECHO_DLY) @(negedge clock);
        echo_drv[k] = 1'b1;
        repeat (width[k]) @(negedge clock);
        echo_drv[k] = 1'b0;
      end
    end
  endtask

  initial sensor(0);
  initial sensor(1);
  initial sensor(2);

  // Monitor: pops the scoreboard on every pronto pulse.
  initial begin
    logic last_p;
    exp_t ex;
    last_p = 1'b0;
    forever begin
      @(negedge clock);
      if ($countones(trig) > 1) overlap_seen = 1'b1;
      if (last_p) check("pronto_one_cycle", {31'd0, pronto}, 32'd0);
      last_p = pronto;
      if (pronto === 1'b1) begin
        pronto_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_pronto", 32'd1, 32'd0);
        end else begin
          ex = sb.pop_front();
          $display("pronto [%s]: distancia=%0d validos=%b erro=%0d", ex.tag,
                   distancia, validos, erro);
          check({ex.tag, "_distancia"}, {23'd0, distancia}, {23'd0, ex.d});
          check({ex.tag, "_validos"}, {29'd0, validos}, {29'd0, ex.v});
          check({ex.tag, "_erro"}, {31'd0, erro}, {31'd0, ex.e});
        end
      end
    end
  end

  task automatic run_cycle(input string tag, input int w0, input int w1, input int w2,
                           input logic [8:0] d, input logic [2:0] v, input logic e);
    exp_t ex;
    int   start;
    bit   seen;
    width[0] = w0;
    width[1] = w1;
    width[2] = w2;
    ex.d = d; ex.v = v; ex.e = e; ex.tag = tag;
    sb.push_back(ex);
    start = pronto_cnt;
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    check({tag, "_medir_to_trigger1"}, {31'd0, trigger1}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clock);
      if (pronto_cnt != start) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_pronto_timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic wait_until(input string name, input int which);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      if (which == 0 && trigger2 === 1'b1) ok = 1'b1;
      if (which == 1 && db_estado === 4'd3) ok = 1'b1;
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_distancia", {23'd0, distancia}, 32'd0);
    check("rst_validos", {29'd0, validos}, 32'd0);
    check("rst_erro", {31'd0, erro}, 32'd0);
    check("rst_pronto", {31'd0, pronto}, 32'd0);
    check("rst_triggers", {29'd0, trig}, 32'd0);
    check("rst_estado", {28'd0, db_estado}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

`ifdef MEDIANA_EN
    run_cycle("all745",      745, 745, 745,  9'd74, 3'b111, 1'b0);
    run_cycle("median",       12, 117, 435,  9'd11, 3'b111, 1'b0);
    run_cycle("trunc_edge",    9,  10,  19,   9'd1, 3'b111, 1'b0);
    run_cycle("s2_silent",   117,   0, 117,  9'd11, 3'b101, 1'b0);
    run_cycle("no_echo",       0,   0,   0,  9'd11, 3'b000, 1'b1);
    run_cycle("s1_stuck",   1200, 205, 309,  9'd20, 3'b110, 1'b0);
`else
    run_cycle("all745",      745, 745, 745,  9'd74, 3'b111, 1'b0);
    run_cycle("median",       12, 117, 435,   9'd1, 3'b111, 1'b0);
    run_cycle("trunc_edge",    9,  10,  19,   9'd0, 3'b111, 1'b0);
    run_cycle("s2_silent",   117,   0, 117,  9'd11, 3'b101, 1'b0);
    run_cycle("no_echo",       0,   0,   0,  9'd11, 3'b000, 1'b1);
    run_cycle("s1_stuck",   1200, 205, 309,  9'd11, 3'b110, 1'b1);
`endif

    // Reset in the middle of sensor 2's measurement: no pronto expected.
    width[0] = 745; width[1] = 205; width[2] = 309;
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_until("reach_trigger2", 0);
    wait_until("reach_mede_s2", 1);
    repeat (20) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    $display("reset applied mid-measurement: estado=%0d trigger2=%0d", db_estado, trigger2);
    check("midrst_estado", {28'd0, db_estado}, 32'd0);
    check("midrst_trigger2", {31'd0, trigger2}, 32'd0);
    check("midrst_distancia", {23'd0, distancia}, 32'd0);
    check("midrst_validos", {29'd0, validos}, 32'd0);
    check("midrst_erro", {31'd0, erro}, 32'd0);
    check("midrst_pronto", {31'd0, pronto}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (300) @(negedge clock);
    run_cycle("after_reset", 745, 745, 745, 9'd74, 3'b111, 1'b0);

    repeat (10) @(negedge clock);
    check("pending_expected", sb.size(), 32'd0);
    check("single_trigger", {31'd0, overlap_seen}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
